imem_responder: RTL

- Instruction-memory responder: the memory side of the fetch read interface.
- Accepts read requests carrying a byte PC and returns 32-bit instruction words in request order after a fixed pipeline latency.
- Buffers responses so fetch/decode back-pressure never drops an instruction.
- Supports flush on branch redirect, and a write port used to load the program image in test benches and at boot.

---
 rtl/imem_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// imem_responder: instruction memory behind a fixed-latency read pipeline and a credit-managed response queue.
// Define IMEM_PERF_CNT_EN to add the accepted-request and stall counters.
module imem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned LATENCY     = 1,
   parameter int unsigned QDEPTH      = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_req_valid,
   output logic                           o_req_ready,
   input  logic [31:0]                    i_req_addr,
   output logic                           o_rsp_valid,
   input  logic                           i_rsp_ready,
   output logic [31:0]                    o_rsp_data,
   output logic [31:0]                    o_rsp_addr,
   output logic                           o_rsp_err,
   input  logic                           i_flush,
   input  logic                           i_ld_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_ld_addr,
   input  logic [31:0]                    i_ld_data,
   output logic [31:0]                    o_req_count,
   output logic [31:0]                    o_stall_count
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned QW = $clog2(QDEPTH);
   localparam int unsigned CW = QW + 2;
   localparam int unsigned PW = 65;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [PW-1:0] q [QDEPTH];

   logic          accept;
   logic          push;
   logic          pop;
   logic [31:0]   woff;
   logic          req_err;
   logic [PW-1:0] req_pkt;
   logic [PW-1:0] last_pkt;
   logic          last_v;
   logic [CW-1:0] dly_cnt;
   logic [CW-1:0] outstanding;
   logic [QW:0]   cnt;
   logic [QW-1:0] wp;
   logic [QW-1:0] rp;

   always_ff @(posedge i_clk) begin
      if (i_ld_en) mem[i_ld_addr] <= i_ld_data;
   end

   // Word offset from the base; wrap-around makes low addresses land out of range.
   assign woff    = (i_req_addr - BASE_ADDR) >> 2;
   assign req_err = (i_req_addr[1:0] != 2'b00) ||
                    (woff >= 32'(DEPTH_WORDS));
   assign req_pkt = {req_err ? NOP : mem[woff[AW-1:0]],
                     i_req_addr, req_err};

   assign accept      = i_req_valid && o_req_ready;
   assign outstanding = CW'(cnt) + dly_cnt;
   assign o_req_ready = i_rst_n && !i_flush &&
                        (outstanding < CW'(QDEPTH));

   // The read is captured at the accept edge; extra stages only delay it.
   generate
      if (LATENCY == 1) begin : g_nodly
         assign last_v   = accept;
         assign last_pkt = req_pkt;
         assign dly_cnt  = '0;
      end else begin : g_dly
         logic [LATENCY-2:0] dv;
         logic [PW-1:0]      dp [LATENCY-1];

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               dv <= '0;
            end else if (i_flush) begin
               dv <= '0;
            end else begin
               dv[0] <= accept;
               for (int i = 1; i < int'(LATENCY) - 1; i++)
                  dv[i] <= dv[i-1];
            end
         end

         always_ff @(posedge i_clk) begin
            dp[0] <= req_pkt;
            for (int i = 1; i < int'(LATENCY) - 1; i++)
               dp[i] <= dp[i-1];
         end

         always_comb begin
            dly_cnt = '0;
            for (int i = 0; i < int'(LATENCY) - 1; i++)
               dly_cnt = dly_cnt + CW'(dv[i]);
         end

         assign last_v   = dv[LATENCY-2];
         assign last_pkt = dp[LATENCY-2];
      end
   endgenerate

   assign push = last_v && !i_flush;
   assign pop  = (cnt != '0) && i_rsp_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (i_flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + QW'(1);
         if (pop)  rp <= rp + QW'(1);
         cnt <= cnt + (QW+1)'(push) - (QW+1)'(pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) q[wp] <= last_pkt;
   end

   assign o_rsp_valid = (cnt != '0);
   assign {o_rsp_data, o_rsp_addr, o_rsp_err} = q[rp];

`ifdef IMEM_PERF_CNT_EN
   logic [31:0] req_count;
   logic [31:0] stall_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         req_count   <= '0;
         stall_count <= '0;
      end else begin
         if (accept) req_count <= req_count + 32'd1;
         if (i_req_valid && !o_req_ready)
            stall_count <= stall_count + 32'd1;
      end
   end

   assign o_req_count   = req_count;
   assign o_stall_count = stall_count;
`else
   assign o_req_count   = '0;
   assign o_stall_count = '0;
`endif

endmodule
